// File: rtl/de1_blinker_nios2_proc_ocimem_ctrl.sv
// On-chip debug RAM access controller: decodes JTAG monitor commands into
// single-word RAM reads/writes with stall timeout and sticky error reporting.
module de1_blinker_nios2_proc_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] ociram_addr,
  output logic [31:0]       ociram_wr_data,
  output logic              ociram_wr_en,
  output logic              ociram_rd_en,
  input  logic              ociram_waitrequest,
  input  logic [31:0]       ociram_rd_data,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       mond_q, mond_d;
  logic [ADDR_W-1:0] mona_q, mona_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic busy, cmd_a_mem, cmd_mem, err_set, err_clr, timed_out;

  assign busy      = (state_q != IDLE);
  assign cmd_a_mem = take_action_ocimem_a & jdo[35];
  // B and read-next only count when A is absent: lower priority strobes are dropped silently
  assign cmd_mem   = cmd_a_mem |
                     (~take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a));
  assign err_clr   = take_action_ocimem_a & ~jdo[35] & jdo[33];
  assign timed_out = (stall_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    mond_d  = mond_q;
    mona_d  = mona_q;
    ready_d = ready_q;
    stall_d = stall_q;
    err_set = 1'b0;

    case (state_q)
      RD_REQ, WR_REQ: begin
        if (!ociram_waitrequest) begin
          if (state_q == RD_REQ) begin
            state_d = RD_DATA;
          end else begin
            mona_d  = mona_q + ADDR_W'(1);
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else if (timed_out) begin
          err_set = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      RD_DATA: begin
        mond_d  = ociram_rd_data;
        mona_d  = mona_q + ADDR_W'(1);
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase

    if (cmd_mem && busy) begin
      err_set = 1'b1;
    end else if (cmd_mem) begin
      if (cmd_a_mem) begin
        mona_d = jdo[ADDR_W+9:10];
        if (jdo[34]) begin
          state_d = RD_REQ;
          stall_d = '0;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end else if (take_action_ocimem_b) begin
        mond_d  = jdo[34:3];
        state_d = WR_REQ;
        stall_d = '0;
        ready_d = 1'b0;
      end else begin
        state_d = RD_REQ;
        stall_d = '0;
        ready_d = 1'b0;
      end
    end

    // A fresh fault in the same cycle as a clear leaves the flag set
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mond_q  <= '0;
      mona_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mond_q  <= mond_d;
      mona_q  <= mona_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign ociram_rd_en   = (state_q == RD_REQ);
  assign ociram_wr_en   = (state_q == WR_REQ);
  assign ociram_addr    = mona_q;
  assign ociram_wr_data = mond_q;
  assign MonDReg        = mond_q;
  assign MonAReg        = mona_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;

  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

endmodule

// File: tb/tb_de1_blinker_nios2_proc_ocimem_ctrl.sv
// Bench for the debug RAM controller: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model and a RAM model.
module tb_de1_blinker_nios2_proc_ocimem_ctrl;
  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          ta, tbs, tn;
  logic [AW-1:0] ociram_addr;
  logic [31:0]   ociram_wr_data;
  logic          ociram_wr_en, ociram_rd_en;
  logic          wreq;
  logic [31:0]   rd_data;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error;

  de1_blinker_nios2_proc_ocimem_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_action_ocimem_b(tbs), .take_no_action_ocimem_a(tn),
    .ociram_addr(ociram_addr), .ociram_wr_data(ociram_wr_data),
    .ociram_wr_en(ociram_wr_en), .ociram_rd_en(ociram_rd_en),
    .ociram_waitrequest(wreq), .ociram_rd_data(rd_data),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  // RAM: data valid the cycle after an accepted read, junk otherwise
  always @(posedge clk) begin
    if (ociram_rd_en && !wreq) rd_data <= mem[ociram_addr];
    else rd_data <= $urandom;
  end

  // Transaction-level model: pending op (0 none, 1 read, 2 write)
  int          pend;
  bit          rd_wait;
  int          stalls;
  logic [7:0]  m_addr;
  logic [31:0] m_data, exp_rd;
  bit          m_ready, m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit idle, eset, eclr;
    if (!reset_n) begin
      pend = 0; rd_wait = 0; stalls = 0;
      m_addr = '0; m_data = '0; m_ready = 0; m_err = 0;
      return;
    end
    idle = (pend == 0); eset = 0; eclr = 0;
    if (pend == 1 && rd_wait) begin
      m_data = exp_rd; m_addr++; m_ready = 1; pend = 0; rd_wait = 0;
    end else if (pend != 0) begin
      if (!wreq) begin
        if (pend == 1) begin
          rd_wait = 1; exp_rd = mem[m_addr];
        end else begin
          mem[m_addr] = m_data; m_addr++; m_ready = 1; pend = 0;
        end
      end else begin
        stalls++;
        if (stalls == TO) begin eset = 1; m_ready = 1; pend = 0; end
      end
    end
    if (ta) begin
      if (jdo[35]) begin
        if (!idle) eset = 1;
        else begin
          m_addr = jdo[17:10];
          if (jdo[34]) begin pend = 1; stalls = 0; m_ready = 0; end
          else m_ready = 1;
        end
      end else if (jdo[33]) eclr = 1;
    end else if (tbs || tn) begin
      if (!idle) eset = 1;
      else if (tbs) begin m_data = jdo[34:3]; pend = 2; stalls = 0; m_ready = 0; end
      else begin pend = 1; stalls = 0; m_ready = 0; end
    end
    if (eset) m_err = 1;
    else if (eclr) m_err = 0;
  endtask

  task automatic compare();
    bit e_rd, e_wr;
    e_rd = (pend == 1) && !rd_wait;
    e_wr = (pend == 2);
    chk("rd_en", ociram_rd_en, e_rd);
    chk("wr_en", ociram_wr_en, e_wr);
    chk("MonAReg", MonAReg, m_addr);
    chk("MonDReg", MonDReg, m_data);
    chk("monitor_ready", monitor_ready, m_ready);
    chk("monitor_error", monitor_error, m_err);
    if (e_rd || e_wr) chk("ociram_addr", ociram_addr, m_addr);
    if (e_wr) chk("ociram_wr_data", ociram_wr_data, m_data);
  endtask

  task automatic step(input bit a, input bit b, input bit n, input logic [37:0] j,
                      input bit w, input bit r);
    ta = a; tbs = b; tn = n; jdo = j; wreq = w; reset_n = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  function automatic logic [37:0] cmd_a(input logic [7:0] ad, input bit rd);
    logic [37:0] j;
    j = '0; j[35] = 1'b1; j[34] = rd; j[17:10] = ad;
    return j;
  endfunction

  function automatic logic [37:0] cmd_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  function automatic logic [37:0] clr_e();
    logic [37:0] j;
    j = '0; j[33] = 1'b1;
    return j;
  endfunction

  initial begin
    int wr_cnt;
    logic [63:0] rv;
    bit heavy;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hDEADBEEF;
    ta = 0; tbs = 0; tn = 0; jdo = '0; wreq = 0; reset_n = 0;
    @(negedge clk);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    chk("reset MonDReg", MonDReg, 32'h0);
    chk("reset MonAReg", MonAReg, 32'h0);
    chk("reset ready", monitor_ready, 1'b0);
    chk("reset error", monitor_error, 1'b0);
    chk("reset enables", {ociram_rd_en, ociram_wr_en}, 2'b00);

    // Read at 0x10, no stall
    step(1, 0, 0, cmd_a(8'h10, 1), 0, 1);
    chk("rd020 rd_en", ociram_rd_en, 1'b1);
    chk("rd020 addr", ociram_addr, 8'h10);
    step(0, 0, 0, '0, 0, 1);
    chk("rd020 rd_en one cycle", ociram_rd_en, 1'b0);
    chk("rd020 not ready yet", monitor_ready, 1'b0);
    step(0, 0, 0, '0, 0, 1);
    chk("rd020 ready", monitor_ready, 1'b1);
    chk("rd020 MonDReg", MonDReg, 32'hDEADBEEF);
    chk("rd020 MonAReg", MonAReg, 8'h11);

    // Write at 0xFF with four stalled cycles, address wraps
    step(1, 0, 0, cmd_a(8'hFF, 0), 0, 1);
    chk("addr load ready", monitor_ready, 1'b1);
    step(0, 1, 0, cmd_b(32'h12345678), 0, 1);
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (ociram_wr_en && ociram_addr == 8'hFF && ociram_wr_data == 32'h12345678) wr_cnt++;
      step(0, 0, 0, '0, i < 4, 1);
    end
    chk("wr021 cycles", wr_cnt, 5);
    chk("wr021 wr_en off", ociram_wr_en, 1'b0);
    chk("wr021 MonAReg wrap", MonAReg, 8'h00);

    // Read timeout then error clear
    step(0, 0, 1, '0, 0, 1);
    for (int i = 0; i < TO; i++) begin
      chk("to022 rd_en held", ociram_rd_en, 1'b1);
      step(0, 0, 0, '0, 1, 1);
    end
    chk("to022 rd_en dropped", ociram_rd_en, 1'b0);
    chk("to022 error", monitor_error, 1'b1);
    chk("to022 ready", monitor_ready, 1'b1);
    chk("to022 MonAReg", MonAReg, 8'h00);
    step(1, 0, 0, clr_e(), 0, 1);
    chk("to022 cleared", monitor_error, 1'b0);

    // Command B while reading is rejected; A+B together runs only A
    step(0, 0, 1, '0, 0, 1);
    step(0, 1, 0, cmd_b(32'hCAFE0000), 1, 1);
    chk("b023 error", monitor_error, 1'b1);
    chk("b023 no write", ociram_wr_en, 1'b0);
    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 1);
    step(1, 1, 0, cmd_a(8'h40, 0), 0, 1);
    chk("ab023 MonAReg", MonAReg, 8'h40);
    step(0, 0, 0, '0, 0, 1);
    chk("ab023 no write", ociram_wr_en, 1'b0);
    step(1, 0, 0, clr_e(), 0, 1);

    // Reset during a stalled write
    step(0, 1, 0, cmd_b(32'hA5A5A5A5), 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 0);
    chk("rst024 wr_en", ociram_wr_en, 1'b0);
    chk("rst024 MonAReg", MonAReg, 8'h00);
    chk("rst024 MonDReg", MonDReg, 32'h0);
    step(0, 0, 1, '0, 0, 1);
    chk("rst024 read-next rd_en", ociram_rd_en, 1'b1);
    chk("rst024 read-next addr", ociram_addr, 8'h00);

    // Random traffic
    heavy = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) heavy = ($urandom_range(0, 3) == 0);
      rv = {$urandom, $urandom};
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           rv[37:0], heavy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 3),
           $urandom_range(0, 299) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/de1_blinker_nios2_proc_ocimem_ctrl.md
DE1_BLINKER_NIOS2_PROC_OCIMEM_CTRL -- requirements
Module: de1_blinker_nios2_proc_ocimem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning word-address width of the on-chip debug RAM.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of waitrequest-stalled cycles before an access aborts.
REQ-003 The block SHALL use one clock, clk; reset_n is synchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  synchronous active-low reset.
- jdo  in  38  debug command payload from the JTAG sysclk stage; valid only in a cycle where a take_* strobe is high.
- take_action_ocimem_a  in  1  one-cycle strobe for command A (address load, optional read, or error clear).
- take_action_ocimem_b  in  1  one-cycle strobe for command B (write data at current address).
- take_no_action_ocimem_a  in  1  one-cycle strobe for read-next at current address.
- ociram_addr  out  ADDR_W  debug RAM word address.
- ociram_wr_data  out  32  debug RAM write data.
- ociram_wr_en  out  1  write request, held until accepted.
- ociram_rd_en  out  1  read request, held until accepted.
- ociram_waitrequest  in  1  RAM stall; a request is accepted in a cycle where its enable is high and waitrequest is low.
- ociram_rd_data  in  32  read data, valid exactly one cycle after read acceptance.
- MonDReg  out  32  monitor data register, returned to the JTAG tck stage.
- MonAReg  out  ADDR_W  current monitor word address.
- monitor_ready  out  1  last command completed.
- monitor_error  out  1  sticky error flag.

Function
REQ-005 The FSM SHALL have states IDLE, RD_REQ, RD_DATA and WR_REQ.
REQ-006 Command A is decoded from jdo:
- jdo[35]=1: MonAReg <= jdo[ADDR_W+9:10].
- jdo[35]=1 and jdo[34]=1: additionally go to RD_REQ.
- jdo[35]=1 and jdo[34]=0: no memory access; monitor_ready <= 1.
- jdo[35]=0 and jdo[33]=1: clear monitor_error; no other effect.
REQ-007 Command B SHALL load MonDReg <= jdo[34:3] and go to WR_REQ.
REQ-008 Read-next SHALL go to RD_REQ using the current MonAReg.
REQ-009 Memory commands are accepted only in IDLE; accepting one SHALL clear monitor_ready in the following cycle.
REQ-010 If a memory command arrives outside IDLE, the block SHALL ignore it and set monitor_error. The error-clear form of command A is honoured in any state.
REQ-011 If strobes coincide, priority SHALL be command A > command B > read-next; lower-priority strobes are dropped without error.
REQ-012 RD_REQ: ociram_rd_en=1 and ociram_addr=MonAReg; on acceptance go to RD_DATA.
REQ-013 RD_DATA: MonDReg <= ociram_rd_data; MonAReg increments; monitor_ready <= 1; go to IDLE. End-to-end latency from strobe to monitor_ready is 3 cycles with no stall.
REQ-014 WR_REQ: ociram_wr_en=1, ociram_addr=MonAReg, ociram_wr_data=MonDReg; on acceptance MonAReg increments, monitor_ready <= 1, go to IDLE.
REQ-015 MonAReg SHALL wrap from 2^ADDR_W-1 to 0.
REQ-016 A stall counter SHALL clear on entry to RD_REQ or WR_REQ and increment on each stalled cycle. When it reaches TIMEOUT, the block SHALL drop the request, leave MonAReg and MonDReg unchanged, and set monitor_error=1 and monitor_ready=1, then go to IDLE.
REQ-017 ociram_rd_en and ociram_wr_en SHALL never be high together, and SHALL be 0 in IDLE and RD_DATA.

Reset
REQ-018 When reset_n=0 at a clock edge, the block SHALL set state=IDLE, MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, both enables=0 and stall counter=0. Reset takes priority over any strobe.
REQ-019 Reset mid-access SHALL abandon the request immediately with no address increment. After reset the block accepts commands on the first cycle with reset_n=1.

Verification
REQ-020 Command A with addr 0x10 and read, rd_data 0xDEADBEEF, no stall -> rd_en for 1 cycle at addr 0x10; MonDReg=0xDEADBEEF; MonAReg=0x11; monitor_ready rises 3 cycles after the strobe.
REQ-021 Command B with jdo[34:3]=0x12345678 at MonAReg=0xFF, waitrequest high for 4 cycles -> wr_en held 5 cycles with data 0x12345678 at addr 0xFF; MonAReg=0x00 afterwards.
REQ-022 Read with waitrequest stuck high -> rd_en deasserts after TIMEOUT stalled cycles; monitor_error=1, monitor_ready=1, MonAReg unchanged; a following command A error-clear -> monitor_error=0.
REQ-023 Command B strobe during RD_REQ -> ignored, no write issued, monitor_error=1; command A and command B in the same cycle -> only command A executes.
REQ-024 reset_n=0 during WR_REQ stall -> next cycle wr_en=0, all outputs at reset values, and a read-next issued afterwards reads addr 0.
